// File: rtl/jogo_sequencia_param.sv
// Genius-style memory game: FSM, key edge detector, address/round counters.
// Define JOGO_TIMEOUT_EN to build the per-jogada timer and the FIM_TIMEOUT end state.
module jogo_sequencia_param #(
    parameter int NCH            = 4,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic [NCH-1:0]           chaves,
    input  logic [NCH-1:0]           mem_dado,
    output logic [$clog2(DEPTH)-1:0] mem_endereco,
    output logic                     acertou,
    output logic                     errou,
    output logic                     timeout,
    output logic                     pronto,
    output logic [NCH-1:0]           leds,
    output logic                     db_igual,
    output logic [$clog2(DEPTH)-1:0] db_rodada,
    output logic [3:0]               db_estado,
    output logic [NCH-1:0]           db_jogada,
    output logic                     db_tem_jogada
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || TIMEOUT_CICLOS < 2) begin : g_param_check
        $error("jogo_sequencia_param: DEPTH and TIMEOUT_CICLOS must be >= 2");
    end

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROX_JOGADA = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t         state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   round_q, round_d;
    logic [NCH-1:0]  jogada_q, jogada_d;
    logic            prev_q;
    logic            acertou_q, errou_q, pronto_q;
    logic            tem, igual, ativo;

    assign tem   = (|chaves) & ~prev_q;
    assign igual = (jogada_q == mem_dado);
    assign ativo = (state_q != INICIAL);

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q;
    logic          expirou;

    assign expirou = (timer_q == TW'(TIMEOUT_CICLOS - 1));
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state and datapath control; the timer restarts on every path back into ESPERA.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        round_d  = round_q;
        jogada_d = jogada_q;
`ifdef JOGO_TIMEOUT_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            INICIAL: begin
                if (iniciar) state_d = PREPARA;
            end
            PREPARA: begin
                addr_d   = '0;
                round_d  = '0;
                jogada_d = '0;
`ifdef JOGO_TIMEOUT_EN
                timer_d  = '0;
`endif
                state_d  = ESPERA;
            end
            ESPERA: begin
`ifdef JOGO_TIMEOUT_EN
                timer_d = timer_q + 1'b1;
                if (tem)          state_d = REGISTRA;
                else if (expirou) state_d = FIM_TIMEOUT;
`else
                if (tem) state_d = REGISTRA;
`endif
            end
            REGISTRA: begin
                jogada_d = chaves;
`ifdef JOGO_TIMEOUT_EN
                timer_d  = '0;
`endif
                state_d  = COMPARA;
            end
            COMPARA: begin
                if (!igual)                             state_d = FIM_ERROU;
                else if (addr_q < round_q)              state_d = PROX_JOGADA;
                else if (round_q == AW'(DEPTH - 1))     state_d = FIM_ACERTOU;
                else                                    state_d = PROX_RODADA;
            end
            PROX_JOGADA: begin
                addr_d  = addr_q + 1'b1;
`ifdef JOGO_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = ESPERA;
            end
            PROX_RODADA: begin
                round_d = round_q + 1'b1;
                addr_d  = '0;
`ifdef JOGO_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = ESPERA;
            end
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            FIM_ACERTOU,
            FIM_ERROU: begin
                if (iniciar) state_d = PREPARA;
            end
            default: begin
                addr_d   = '0;
                round_d  = '0;
                jogada_d = '0;
                state_d  = INICIAL;
            end
        endcase
    end

    // State, counters and Moore flags; flags are decoded from the next state so they line up with db_estado.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= INICIAL;
            addr_q    <= '0;
            round_q   <= '0;
            jogada_q  <= '0;
            prev_q    <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            pronto_q  <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            round_q   <= round_d;
            jogada_q  <= jogada_d;
            prev_q    <= |chaves;
            acertou_q <= (state_d == FIM_ACERTOU);
            errou_q   <= (state_d == FIM_ERROU);
            pronto_q  <= (state_d == FIM_ACERTOU) || (state_d == FIM_ERROU) ||
                         (state_d == FIM_TIMEOUT);
`ifdef JOGO_TIMEOUT_EN
            timer_q   <= timer_d;
            timeout_q <= (state_d == FIM_TIMEOUT);
`endif
        end
    end

    assign mem_endereco  = addr_q;
    assign db_rodada     = round_q;
    assign db_estado     = state_q;
    assign leds          = jogada_q;
    assign db_jogada     = jogada_q;
    assign acertou       = acertou_q;
    assign errou         = errou_q;
    assign pronto        = pronto_q;
    assign db_igual      = ativo & igual;
    assign db_tem_jogada = ativo & tem;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: table-driven game vectors through a scoreboard queue,
// plus hand-written restart, timeout, held-key and mid-game reset sequences.
module tb_jogo_sequencia_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic [3:0] memDado;
    logic [1:0] memEndereco;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] leds, dbJogada, dbEstado;
    logic       dbIgual, dbTemJogada;
    logic [1:0] dbRodada;

    logic [3:0] rom [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
    assign memDado = rom[memEndereco];

    always #5 clock = ~clock;

    jogo_sequencia_param #(.NCH(4), .DEPTH(4), .TIMEOUT_CICLOS(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .chaves       (chaves),
        .mem_dado     (memDado),
        .mem_endereco (memEndereco),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .pronto       (pronto),
        .leds         (leds),
        .db_igual     (dbIgual),
        .db_rodada    (dbRodada),
        .db_estado    (dbEstado),
        .db_jogada    (dbJogada),
        .db_tem_jogada(dbTemJogada)
    );

    typedef struct {
        logic [3:0] keys;
        logic [3:0] estado;
        logic [1:0] rodada;
        logic [1:0] endereco;
        logic       igual;
    } vec_t;

    vec_t        vecs [13];
    logic [21:0] sbQueue [$];
    string       nameQueue [$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [21:0] actualVec();
        return {dbEstado, acertou, errou, timeout, pronto, dbRodada, memEndereco,
                leds, dbJogada, dbIgual, dbTemJogada};
    endfunction

    function automatic logic [21:0] mk(logic [3:0] est, logic [1:0] rod, logic [1:0] ender,
                                       logic [3:0] ld, logic ig);
        logic ac, er, to;
        ac = (est == 4'hA);
        er = (est == 4'hE);
        to = (est == 4'hD);
        return {est, ac, er, to, ac | er | to, rod, ender, ld, ld, ig, 1'b0};
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        iniciar = 1'b0;
        chaves = 4'd0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic startGame();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    // One pulsed jogada: key held across REGISTRA, result popped once the DUT leaves REGISTRA/COMPARA.
    task automatic applyStimulus(vec_t v, string name);
        int n;
        n = 0;
        while (dbEstado != 4'h2 && n < 10) begin
            tick();
            n++;
        end
        if (dbEstado != 4'h2) checkOutput({name, "_wait_espera"}, 32'(dbEstado), 32'h2);
        sbQueue.push_back(mk(v.estado, v.rodada, v.endereco, v.keys, v.igual));
        nameQueue.push_back(name);
        chaves = v.keys;
        tick();
        tick();
        chaves = 4'd0;
        n = 0;
        do begin
            tick();
            n++;
        end while ((dbEstado == 4'h3 || dbEstado == 4'h4) && n < 8);
        checkOutput(nameQueue.pop_front(), 32'(actualVec()), 32'(sbQueue.pop_front()));
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;
        // keys, resulting state, rodada, endereco, igual
        vecs[0]  = '{4'd1, 4'h6, 2'd0, 2'd0, 1'b1};
        vecs[1]  = '{4'd1, 4'h5, 2'd1, 2'd0, 1'b1};
        vecs[2]  = '{4'd2, 4'h6, 2'd1, 2'd1, 1'b1};
        vecs[3]  = '{4'd1, 4'h5, 2'd2, 2'd0, 1'b1};
        vecs[4]  = '{4'd2, 4'h5, 2'd2, 2'd1, 1'b1};
        vecs[5]  = '{4'd4, 4'h6, 2'd2, 2'd2, 1'b1};
        vecs[6]  = '{4'd1, 4'h5, 2'd3, 2'd0, 1'b1};
        vecs[7]  = '{4'd2, 4'h5, 2'd3, 2'd1, 1'b1};
        vecs[8]  = '{4'd4, 4'h5, 2'd3, 2'd2, 1'b1};
        vecs[9]  = '{4'd8, 4'hA, 2'd3, 2'd3, 1'b1};
        vecs[10] = '{4'd1, 4'h6, 2'd0, 2'd0, 1'b1};
        vecs[11] = '{4'd1, 4'h5, 2'd1, 2'd0, 1'b1};
        vecs[12] = '{4'd4, 4'hE, 2'd1, 2'd1, 1'b0};

        doReset();
        checkOutput("reset_state", 32'(actualVec()), 32'(22'd0));

        startGame();
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("win_jogada%0d", i));

        iniciar = 1'b1;
        tick();
        checkOutput("restart_prepara", 32'(dbEstado), 32'h1);
        iniciar = 1'b0;
        tick();
        checkOutput("restart_espera", 32'(actualVec()), 32'(mk(4'h2, 2'd0, 2'd0, 4'd0, 1'b0)));

        for (int i = 10; i < 13; i++) applyStimulus(vecs[i], $sformatf("err_jogada%0d", i - 10));
        repeat (5) tick();
        checkOutput("err_hold", 32'(actualVec()), 32'(mk(4'hE, 2'd1, 2'd1, 4'd4, 1'b0)));

        doReset();
        startGame();
        repeat (7) tick();
        checkOutput("timeout_window", 32'(dbEstado), 32'h2);
        tick();
`ifdef JOGO_TIMEOUT_EN
        checkOutput("timeout_fired", 32'(actualVec()), 32'(mk(4'hD, 2'd0, 2'd0, 4'd0, 1'b0)));
`else
        repeat (100) tick();
        checkOutput("no_timeout_wait", 32'(actualVec()), 32'(mk(4'h2, 2'd0, 2'd0, 4'd0, 1'b0)));
`endif

        doReset();
        startGame();
        pulses = 0;
        chaves = 4'b0001;
        #1;
        pulses += int'(dbTemJogada);
        for (int i = 1; i <= 20; i++) begin
            tick();
            pulses += int'(dbTemJogada);
            if (i == 4)
                checkOutput("held_round_advance", 32'(actualVec()),
                            32'(mk(4'h2, 2'd1, 2'd0, 4'd1, 1'b1)));
        end
        chaves = 4'd0;
        checkOutput("held_single_pulse", 32'(pulses), 32'd1);

        doReset();
        startGame();
        chaves = 4'b0001;
        tick();
        tick();
        checkOutput("reset_pre_compara", 32'(dbEstado), 32'h4);
        reset = 1'b0;
        tick();
        checkOutput("reset_mid_game", 32'(actualVec()), 32'(22'd0));
        reset = 1'b1;
        chaves = 4'd0;
        tick();
        checkOutput("reset_stays_inicial", 32'(actualVec()), 32'(22'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
